// File: rtl/disp_vram_fetch_pkg.sv
// Shared constants for the VRAM-side display fetch path.
// Frame geometry, burst sizing, AXI encodings and the fetch FSM state type.
// No logic; imported by the fetch engine.
package disp_vram_fetch_pkg;

  localparam int HPIX   = 640;
  localparam int VPIX   = 480;
  localparam int BURST  = 128;
  localparam int NBURST = HPIX * VPIX / BURST;

  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

endpackage

// File: rtl/disp_vram_fetch_if.sv
// AXI4 read-only channel bundle (AR + R) between the fetch engine and VRAM.
// Master drives the address and R-ready; slave drives ready, data and response.
// Pure wiring: no latency, flow control is plain AXI valid/ready.
interface disp_vram_fetch_if;

  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  modport master (
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RDATA, RRESP, RLAST, RVALID
  );

endinterface

// File: rtl/disp_vram_fetch_sync_edge.sv
// Brings an asynchronous level into the local clock and flags its rising edge.
// Latency: edge pulse appears 2-3 cycles after the input rises.
// No backpressure: single-cycle pulse, consumer must act on it immediately.
module disp_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic s0_q, s1_q, s2_q;

  // Three-stage capture: s0/s1 resolve metastability, s2 delays for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s0_q <= sig_i;
      s1_q <= s0_q;
      s2_q <= s1_q;
    end
  end

  assign rise_o = s1_q & ~s2_q;

endmodule

// File: rtl/disp_vram_fetch.sv
// Fetches one full frame from VRAM per frame-start request, one AXI burst at a time.
// Latency: AR issued 3-4 cycles after AXISTART rises; each accepted beat reaches FIFO 1 cycle later.
// Backpressure: FIFOFULL drops RREADY only; AR side is never stalled by the FIFO.
module disp_vram_fetch
  import disp_vram_fetch_pkg::*;
#(
  parameter int HPIX_P  = HPIX,
  parameter int VPIX_P  = VPIX,
  parameter int BURST_P = BURST
) (
  input  logic               ACLK,
  input  logic               ARST,
  input  logic               AXISTART,
  input  logic               DISPON,
  input  logic [31:0]        DISPADDR,
  disp_vram_fetch_if.master  axi,
  output logic               FIFOWR,
  output logic [23:0]        FIFOIN,
  input  logic               FIFOFULL,
  output logic               BUSY,
  output logic               RERR
);

  localparam int NB    = HPIX_P * VPIX_P / BURST_P;
  localparam int BCW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int SHIFT = $clog2(BURST_P * 4);
  localparam logic [BCW-1:0] LAST_B = BCW'(NB - 1);

  state_t          state_q, state_d;
  logic [31:0]     base_q, base_d;
  logic [BCW-1:0]  bcnt_q, bcnt_d;
  logic [BCW-1:0]  bcnt_inc;
  logic [31:0]     araddr_q, araddr_d;
  logic            busy_q, busy_d;
  logic            fifowr_q, fifowr_d;
  logic [23:0]     fifoin_q, fifoin_d;
  logic            rerr_q, rerr_d;
  logic            start;
  logic            beat;
  logic            unused_rdata_hi;

  disp_sync_edge u_start_sync (
    .clk    (ACLK),
    .rst    (ARST),
    .sig_i  (AXISTART),
    .rise_o (start)
  );

  assign beat            = axi.RVALID & axi.RREADY;
  assign bcnt_inc        = bcnt_q + BCW'(1);
  assign unused_rdata_hi = ^axi.RDATA[31:24];

  assign axi.ARVALID = (state_q == S_ADDR);
  assign axi.RREADY  = (state_q == S_DATA) & ~FIFOFULL;
  assign axi.ARADDR  = araddr_q;
  assign axi.ARLEN   = 8'(BURST_P - 1);
  assign axi.ARSIZE  = SIZE_4B;
  assign axi.ARBURST = BURST_INCR;

  assign FIFOWR = fifowr_q;
  assign FIFOIN = fifoin_q;
  assign BUSY   = busy_q;
  assign RERR   = rerr_q;

  // Next-state: frame sequencing, burst address generation, FIFO write and error capture.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    bcnt_d   = bcnt_q;
    araddr_d = araddr_q;
    busy_d   = busy_q;
    fifowr_d = beat;
    fifoin_d = beat ? axi.RDATA[23:0] : fifoin_q;
    rerr_d   = rerr_q | (beat & (axi.RRESP != 2'b00));
    case (state_q)
      S_IDLE: begin
        // Base is latched here so later DISPADDR changes only affect the next frame.
        if (start && DISPON) begin
          base_d   = DISPADDR;
          bcnt_d   = '0;
          araddr_d = DISPADDR;
          busy_d   = 1'b1;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (axi.ARREADY) state_d = S_DATA;
      end
      S_DATA: begin
        // Burst boundary follows RLAST alone; beat count is not cross-checked.
        if (beat && axi.RLAST) begin
          if (bcnt_q == LAST_B) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            bcnt_d   = bcnt_inc;
            araddr_d = base_q + (32'(bcnt_inc) << SHIFT);
            state_d  = S_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; synchronous reset returns everything to idle.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      bcnt_q   <= '0;
      araddr_q <= '0;
      busy_q   <= 1'b0;
      fifowr_q <= 1'b0;
      fifoin_q <= '0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      bcnt_q   <= bcnt_d;
      araddr_q <= araddr_d;
      busy_q   <= busy_d;
      fifowr_q <= fifowr_d;
      fifoin_q <= fifoin_d;
      rerr_q   <= rerr_d;
    end
  end

endmodule

// File: tb/tb_disp_vram_fetch.sv
// Directed bench for disp_vram_fetch with a reduced frame (32x4, 16-beat bursts).
// A VRAM slave model answers AR/R at the falling edge and a pixel scoreboard checks FIFO writes.
// Main sequence drives frame requests, resets and error injection at rising edge + 2.
`timescale 1ns/1ps
module tb_disp_vram_fetch;

  localparam int HP     = 32;
  localparam int VP     = 4;
  localparam int BL     = 16;
  localparam int NB     = HP * VP / BL;
  localparam int NPIX   = HP * VP;
  localparam int STRIDE = BL * 4;

  logic        ACLK = 1'b0;
  logic        ARST = 1'b1;
  logic        AXISTART = 1'b0;
  logic        DISPON = 1'b0;
  logic [31:0] DISPADDR = 32'h0;
  logic        FIFOFULL = 1'b0;
  logic        FIFOWR;
  logic [23:0] FIFOIN;
  logic        BUSY;
  logic        RERR;

  disp_vram_fetch_if axi();

  disp_vram_fetch #(.HPIX_P(HP), .VPIX_P(VP), .BURST_P(BL)) dut (
    .ACLK     (ACLK),
    .ARST     (ARST),
    .AXISTART (AXISTART),
    .DISPON   (DISPON),
    .DISPADDR (DISPADDR),
    .axi      (axi),
    .FIFOWR   (FIFOWR),
    .FIFOIN   (FIFOIN),
    .FIFOFULL (FIFOFULL),
    .BUSY     (BUSY),
    .RERR     (RERR)
  );

  always #5 ACLK = ~ACLK;

  int tests  = 0;
  int failed = 0;

  // slave model / scoreboard state
  int          ar_delay = 0;
  int          ar_wait = 0;
  bit          full_mode = 1'b0;
  int          err_burst = -1;
  int          err_beat = -1;
  bit          have_burst = 1'b0;
  bit          ar_pending = 1'b0;
  logic [31:0] burst_addr = 32'h0;
  logic [31:0] held_addr = 32'h0;
  int          beat_i = 0;
  int          burst_no = 0;
  int          ar_count = 0;
  int          wr_count = 0;
  logic [31:0] exp_ar[$];
  logic [23:0] exp_px[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pix(input logic [31:0] a);
    return {8'hC3, a[25:2] ^ 24'h5A5A5A};
  endfunction

  // VRAM slave: drive at falling edge, evaluate handshakes 1 ns later.
  initial begin
    axi.ARREADY = 1'b0;
    axi.RVALID  = 1'b0;
    axi.RDATA   = 32'h0;
    axi.RRESP   = 2'b00;
    axi.RLAST   = 1'b0;
    forever begin
      @(negedge ACLK);
      if (ARST) begin
        axi.ARREADY = 1'b0;
        axi.RVALID  = 1'b0;
        axi.RLAST   = 1'b0;
        axi.RRESP   = 2'b00;
        FIFOFULL    = 1'b0;
        have_burst  = 1'b0;
        ar_pending  = 1'b0;
        ar_wait     = 0;
        exp_px.delete();
        exp_ar.delete();
        continue;
      end
      FIFOFULL    = full_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      axi.ARREADY = axi.ARVALID && !have_burst && (ar_wait >= ar_delay);
      if (have_burst) begin
        axi.RVALID = 1'b1;
        axi.RDATA  = pix(burst_addr + 32'(beat_i * 4));
        axi.RLAST  = (beat_i == BL - 1);
        axi.RRESP  = ((burst_no - 1 == err_burst) && (beat_i == err_beat)) ? 2'b10 : 2'b00;
      end else begin
        axi.RVALID = 1'b0;
        axi.RLAST  = 1'b0;
        axi.RRESP  = 2'b00;
      end
      #1;
      if (FIFOWR) begin
        if (exp_px.size() == 0) check("fifo_extra_write", 32'd1, 32'd0);
        else check("fifo_data", 32'(FIFOIN), 32'(exp_px.pop_front()));
        wr_count++;
      end
      if (have_burst) begin
        check("rready_vs_full", 32'(axi.RREADY), 32'(!FIFOFULL));
        check("one_outstanding", 32'(axi.ARVALID), 32'd0);
      end
      if (axi.RVALID && axi.RREADY) begin
        exp_px.push_back(axi.RDATA[23:0]);
        if (axi.RLAST) have_burst = 1'b0;
        else beat_i++;
      end
      if (axi.ARVALID) begin
        if (ar_pending) check("araddr_stable", axi.ARADDR, held_addr);
        if (axi.ARREADY) begin
          check("ar_wait_cycles", 32'(ar_wait), 32'(ar_delay));
          if (exp_ar.size() == 0) check("ar_extra", 32'd1, 32'd0);
          else check("araddr", axi.ARADDR, exp_ar.pop_front());
          check("arlen", 32'(axi.ARLEN), 32'(BL - 1));
          check("arsize", 32'(axi.ARSIZE), 32'd2);
          check("arburst", 32'(axi.ARBURST), 32'd1);
          have_burst = 1'b1;
          burst_addr = axi.ARADDR;
          beat_i     = 0;
          burst_no++;
          ar_count++;
          ar_pending = 1'b0;
          ar_wait    = 0;
        end else begin
          if (!ar_pending) held_addr = axi.ARADDR;
          ar_pending = 1'b1;
          ar_wait++;
        end
      end else if (ar_pending) begin
        check("arvalid_held", 32'd0, 32'd1);
        ar_pending = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge ACLK);
    #2;
  endtask

  task automatic begin_frame(input logic [31:0] base);
    for (int n = 0; n < NB; n++) exp_ar.push_back(base + 32'(n * STRIDE));
    ar_count = 0;
    wr_count = 0;
    burst_no = 0;
    DISPADDR = base;
    DISPON   = 1'b1;
    AXISTART = 1'b1;
    for (int i = 0; i < 8 && !BUSY; i++) cyc();
    check("busy_rise", 32'(BUSY), 32'd1);
    repeat (3) cyc();
    AXISTART = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (BUSY && n < 5000) begin
      cyc();
      n++;
    end
    check("frame_done_in_time", 32'(BUSY), 32'd0);
    repeat (3) cyc();
    check("ar_count", 32'(ar_count), 32'(NB));
    check("wr_count", 32'(wr_count), 32'(NPIX));
    check("px_queue_empty", 32'(exp_px.size()), 32'd0);
    check("ar_queue_empty", 32'(exp_ar.size()), 32'd0);
  endtask

  initial begin
    bit saw_ar, saw_busy, saw_wr;
    int n;

    // reset values
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_arvalid", 32'(axi.ARVALID), 32'd0);
    check("rst_rready", 32'(axi.RREADY), 32'd0);
    check("rst_fifowr", 32'(FIFOWR), 32'd0);
    check("rst_fifoin", 32'(FIFOIN), 32'd0);
    check("rst_araddr", axi.ARADDR, 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_rerr", 32'(RERR), 32'd0);
    #1;
    ARST = 1'b0;
    repeat (4) cyc();

    // start with display disabled: nothing happens
    DISPADDR = 32'h1000_0000;
    DISPON   = 1'b0;
    AXISTART = 1'b1;
    saw_ar = 0; saw_busy = 0; saw_wr = 0;
    for (int i = 0; i < 15; i++) begin
      if (i == 6) AXISTART = 1'b0;
      cyc();
      saw_ar   |= axi.ARVALID;
      saw_busy |= BUSY;
      saw_wr   |= FIFOWR;
    end
    check("dispoff_arvalid", 32'(saw_ar), 32'd0);
    check("dispoff_busy", 32'(saw_busy), 32'd0);
    check("dispoff_fifowr", 32'(saw_wr), 32'd0);

    // normal frame
    begin_frame(32'h2000_0000);
    wait_done();

    // second start mid-frame with new base and display dropped: ignored
    begin_frame(32'h2000_0000);
    repeat (20) cyc();
    DISPADDR = 32'h3000_0000;
    DISPON   = 1'b0;
    AXISTART = 1'b1;
    repeat (6) cyc();
    AXISTART = 1'b0;
    wait_done();
    saw_ar = 0; saw_busy = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      saw_ar   |= axi.ARVALID;
      saw_busy |= BUSY;
    end
    check("restart_ignored_ar", 32'(saw_ar), 32'd0);
    check("restart_ignored_busy", 32'(saw_busy), 32'd0);

    // FIFO backpressure and slow ARREADY
    full_mode = 1'b1;
    ar_delay  = 5;
    begin_frame(32'h2345_6000);
    wait_done();
    full_mode = 1'b0;
    ar_delay  = 0;

    // read error on beat 10 of burst 3: sticky flag, beat still written
    check("rerr_before", 32'(RERR), 32'd0);
    err_burst = 3;
    err_beat  = 10;
    begin_frame(32'h2000_0000);
    wait_done();
    check("rerr_set", 32'(RERR), 32'd1);
    err_burst = -1;
    err_beat  = -1;
    begin_frame(32'h2000_1000);
    wait_done();
    check("rerr_sticky", 32'(RERR), 32'd1);

    // reset during burst 5
    begin_frame(32'h5000_0000);
    n = 0;
    while (!(burst_no == 6 && beat_i >= 4) && n < 1000) begin
      cyc();
      n++;
    end
    check("reach_burst5", 32'(burst_no == 6 && beat_i >= 4), 32'd1);
    ARST = 1'b1;
    @(posedge ACLK);
    #1;
    check("mid_rst_arvalid", 32'(axi.ARVALID), 32'd0);
    check("mid_rst_rready", 32'(axi.RREADY), 32'd0);
    check("mid_rst_fifowr", 32'(FIFOWR), 32'd0);
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    check("mid_rst_rerr", 32'(RERR), 32'd0);
    check("mid_rst_araddr", axi.ARADDR, 32'd0);
    #1;
    ARST = 1'b0;
    repeat (4) cyc();
    check("post_rst_idle_busy", 32'(BUSY), 32'd0);
    check("post_rst_idle_ar", 32'(axi.ARVALID), 32'd0);

    // fresh frame from a base that wraps past 2^32
    begin_frame(32'hFFFF_FF80);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
